thresholding_out_pack: RTL

//  Downstream neighbour of the thresholding AXI stage. Gathers PACK consecutive input beats of input_SDIM

---
 rtl/thresholding_pkg.sv | 25 ++
 rtl/thresholding_out_pack.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/thresholding_pkg.sv
// Sizing helpers shared with the thresholding AXI stage so code/lane widths
// and byte padding agree on both sides of the stream.
package thresholding_pkg;

    // Round a bit count up to a whole number of bytes (AXI-stream tdata width).
    function automatic int pad8(input int bits);
        return ((bits + 7) / 8) * 8;
    endfunction

    // Width of one input beat's worth of codes.
    function automatic int slice_w(input int sdim, input int obits);
        return sdim * obits;
    endfunction

    // Unpadded width of PACK beats gathered into one word.
    function automatic int word_w(input int pack, input int sdim, input int obits);
        return pack * sdim * obits;
    endfunction

    // Counter width for a modulo-n count; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/thresholding_out_pack.sv
// Gathers PACK input beats of thresholding codes into one wide AXI-stream word.
// Optional end-of-frame marker enabled by `define THRESHOLDING_OUT_PACK_TLAST_EN.
module thresholding_out_pack
    import thresholding_pkg::*;
#(
    parameter int O_BITS      = 4,
    parameter int input_SDIM  = 1,
    parameter int PACK        = 2,
    parameter int FRAME_WORDS = 16
) (
    input  logic                                          ap_clk,
    input  logic                                          ap_rst,
    output logic                                          input_tready,
    input  logic                                          input_tvalid,
    input  logic [pad8(slice_w(input_SDIM, O_BITS))-1:0]  input_tdata,
    input  logic                                          output_tready,
    output logic                                          output_tvalid,
    output logic [pad8(word_w(PACK, input_SDIM, O_BITS))-1:0] output_tdata
`ifdef THRESHOLDING_OUT_PACK_TLAST_EN
    ,
    output logic                                          output_tlast
`endif
);

    localparam int SW = slice_w(input_SDIM, O_BITS);
    localparam int IW = pad8(SW);
    localparam int PW = word_w(PACK, input_SDIM, O_BITS);
    localparam int OW = pad8(PW);
    localparam int CW = cnt_w(PACK);
    localparam logic [CW-1:0] CNT_LAST = CW'(PACK - 1);

    if (PACK < 1) begin : g_chk_pack
        $error("thresholding_out_pack: PACK must be >= 1");
    end
    if (input_SDIM < 1) begin : g_chk_sdim
        $error("thresholding_out_pack: input_SDIM must be >= 1");
    end
    if (O_BITS < 1) begin : g_chk_obits
        $error("thresholding_out_pack: O_BITS must be >= 1");
    end
    if (FRAME_WORDS < 1) begin : g_chk_frame
        $error("thresholding_out_pack: FRAME_WORDS must be >= 1");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] word;
    logic [SW-1:0] beat;
    logic [OW-1:0] data_q, data_d;
    logic          vld_q, vld_d;
    logic          last_beat;
    logic          in_fire;
    logic          out_fire;

    assign beat = input_tdata[SW-1:0];

    if (IW > SW) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^input_tdata[IW-1:SW];
    end

    // Only the completing beat can stall, and only while the output word is stuck.
    assign last_beat     = (cnt_q == CNT_LAST);
    assign input_tready  = !(last_beat && vld_q && !output_tready);
    assign in_fire       = input_tvalid && input_tready;
    assign out_fire      = vld_q && output_tready;
    assign output_tvalid = vld_q;
    assign output_tdata  = data_q;

    // Beat k lands at slice k; untouched slices of acc are still zero.
    assign word = acc_q | (PW'(beat) << (int'(cnt_q) * SW));

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        data_d = data_q;
        vld_d  = vld_q;
        if (out_fire) begin
            vld_d = 1'b0;
        end
        if (in_fire) begin
            if (last_beat) begin
                cnt_d  = '0;
                acc_d  = '0;
                data_d = OW'(word);
                vld_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
                acc_d = word;
            end
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            cnt_q  <= '0;
            acc_q  <= '0;
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

`ifdef THRESHOLDING_OUT_PACK_TLAST_EN
    localparam int FCW = cnt_w(FRAME_WORDS);
    localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_WORDS - 1);

    logic [FCW-1:0] fcnt_q, fcnt_d;
    logic           last_q, last_d;

    // fcnt_d is the frame index of whatever word is loaded this cycle.
    always_comb begin
        fcnt_d = fcnt_q;
        last_d = last_q;
        if (out_fire) begin
            fcnt_d = (fcnt_q == FRAME_LAST) ? '0 : fcnt_q + 1'b1;
        end
        if (in_fire && last_beat) begin
            last_d = (fcnt_d == FRAME_LAST);
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            fcnt_q <= '0;
            last_q <= 1'b0;
        end else begin
            fcnt_q <= fcnt_d;
            last_q <= last_d;
        end
    end

    assign output_tlast = last_q;
`endif

endmodule
